dest_sel_pipe: RTL and testbench

Parametrised register-write destination selector and destination pipeline for the pipelined CPU. Selects the write-back register address from rt, rd or a fixed link register per instruction, then carries address plus write-enable through DEPTH pipeline stages (ID/EX → EX/MEM → MEM/WB for DEPTH=3) with hold and bubble control. Optionally compares two source addresses against all in-flight destinations to drive the forwarding and hazard units.

---
 rtl/dest_sel_pipe_pkg.sv | 18 +
 rtl/dest_match.sv | 32 +++
 rtl/dest_sel_pipe.sv | 124 ++++++++++++
 tb/tb_dest_sel_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dest_sel_pipe_pkg.sv
// Shared definitions for the write-back destination selector and its
// destination pipeline: default widths, destination-mode encodings and
// the hard-wired zero register.
package dest_sel_pipe_pkg;

  localparam int ADDR_W_DEF   = 5;
  localparam int LINK_REG_DEF = 31;
  localparam int ZERO_REG     = 0;

  // Destination field select carried by the decoder
  typedef enum logic [1:0] {
    DST_RT   = 2'b00,
    DST_RD   = 2'b01,
    DST_LINK = 2'b10,
    DST_RSVD = 2'b11
  } dst_mode_e;

endpackage

// File: rtl/dest_match.sv
// Compares one source register address against every in-flight
// destination and reports whether any stage will write it, plus the
// youngest (lowest-index) matching stage. Address zero never matches.
module dest_match
  import dest_sel_pipe_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 3,
  parameter int STG_W  = 2
) (
  input  logic [DEPTH*ADDR_W-1:0] stage_dst_i,
  input  logic [DEPTH-1:0]        stage_we_i,
  input  logic [ADDR_W-1:0]       src_i,
  output logic                    hit_o,
  output logic [STG_W-1:0]        stage_o
);

  // Scan oldest to youngest so the youngest hit is the last one to land
  always_comb begin
    hit_o   = 1'b0;
    stage_o = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (stage_we_i[k] &&
          (stage_dst_i[k*ADDR_W +: ADDR_W] == src_i) &&
          (src_i != ADDR_W'(ZERO_REG))) begin
        hit_o   = 1'b1;
        stage_o = STG_W'(k);
      end
    end
  end

endmodule

// File: rtl/dest_sel_pipe.sv
// Write-back destination selector and destination pipeline.
// Picks rt / rd / link register for the decoding instruction, then carries
// (address, write-enable) through DEPTH stages with hold and bubble control.
// Build option: DEST_FWD_CMP_EN adds source-vs-in-flight comparators for the
// forwarding and hazard units; without it the fwd_* outputs are tied to 0.
module dest_sel_pipe
  import dest_sel_pipe_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DEPTH    = 3,
  parameter int LINK_REG = LINK_REG_DEF,
  localparam int STG_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       rt,
  input  logic [ADDR_W-1:0]       rd,
  input  logic [1:0]              dst_mode,
  input  logic                    reg_write,
  input  logic                    hold,
  input  logic                    bubble,
  input  logic [ADDR_W-1:0]       src_a,
  input  logic [ADDR_W-1:0]       src_b,
  output logic [DEPTH*ADDR_W-1:0] stage_dst,
  output logic [DEPTH-1:0]        stage_we,
  output logic [ADDR_W-1:0]       wb_dst,
  output logic                    wb_we,
  output logic                    fwd_a_hit,
  output logic                    fwd_b_hit,
  output logic [STG_W-1:0]        fwd_a_stage,
  output logic [STG_W-1:0]        fwd_b_stage
);

  logic [ADDR_W-1:0] dst_sel;
  logic              we_sel;
  logic [ADDR_W-1:0] dst_q [DEPTH];
  logic [ADDR_W-1:0] dst_d [DEPTH];
  logic [DEPTH-1:0]  we_q;
  logic [DEPTH-1:0]  we_d;

  // Destination select; reserved mode and $0 targets enter as non-writes
  always_comb begin
    unique case (dst_mode_e'(dst_mode))
      DST_RD:   dst_sel = rd;
      DST_LINK: dst_sel = ADDR_W'(LINK_REG);
      default:  dst_sel = rt;
    endcase
    we_sel = reg_write &&
             (dst_mode_e'(dst_mode) != DST_RSVD) &&
             (dst_sel != ADDR_W'(ZERO_REG));
  end

  // Next-state: hold freezes everything, otherwise shift with a bubble or new entry
  always_comb begin
    dst_d = dst_q;
    we_d  = we_q;
    if (!hold) begin
      dst_d[0] = bubble ? '0   : dst_sel;
      we_d[0]  = bubble ? 1'b0 : we_sel;
      for (int k = 1; k < DEPTH; k++) begin
        dst_d[k] = dst_q[k-1];
        we_d[k]  = we_q[k-1];
      end
    end
  end

  // Stage registers; reset clears every in-flight write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        dst_q[k] <= '0;
      end
      we_q <= '0;
    end else begin
      dst_q <= dst_d;
      we_q  <= we_d;
    end
  end

  // Flatten stage registers onto the output bus
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      stage_dst[k*ADDR_W +: ADDR_W] = dst_q[k];
    end
  end

  assign stage_we = we_q;
  assign wb_dst   = dst_q[DEPTH-1];
  assign wb_we    = we_q[DEPTH-1];

`ifdef DEST_FWD_CMP_EN
  dest_match #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .STG_W  (STG_W)
  ) u_match_a (
    .stage_dst_i (stage_dst),
    .stage_we_i  (we_q),
    .src_i       (src_a),
    .hit_o       (fwd_a_hit),
    .stage_o     (fwd_a_stage)
  );

  dest_match #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .STG_W  (STG_W)
  ) u_match_b (
    .stage_dst_i (stage_dst),
    .stage_we_i  (we_q),
    .src_i       (src_b),
    .hit_o       (fwd_b_hit),
    .stage_o     (fwd_b_stage)
  );
`else
  logic unused_src;
  assign unused_src  = ^{src_a, src_b};
  assign fwd_a_hit   = 1'b0;
  assign fwd_b_hit   = 1'b0;
  assign fwd_a_stage = '0;
  assign fwd_b_stage = '0;
`endif

endmodule

// File: tb/tb_dest_sel_pipe.sv
// Self-checking bench for dest_sel_pipe (DEPTH=3, ADDR_W=5, LINK_REG=31).
// Expected stage contents come from a queue scoreboard: each advancing edge
// pushes the entry the bench expects to enter stage 0, the queue front is the
// youngest stage, and the entry falling off the back is what left wb.
module tb_dest_sel_pipe;

  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int SW    = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [AW-1:0]     rt, rd, src_a, src_b;
  logic [1:0]        dst_mode;
  logic              reg_write, hold, bubble;
  logic [DEPTH*AW-1:0] stage_dst;
  logic [DEPTH-1:0]  stage_we;
  logic [AW-1:0]     wb_dst;
  logic              wb_we;
  logic              fwd_a_hit, fwd_b_hit;
  logic [SW-1:0]     fwd_a_stage, fwd_b_stage;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [AW-1:0] dst;
    logic          we;
  } ent_t;

  ent_t exp_q[$];

  dest_sel_pipe #(.ADDR_W(AW), .DEPTH(DEPTH), .LINK_REG(31)) dut (
    .clk         (clk),
    .reset       (reset),
    .rt          (rt),
    .rd          (rd),
    .dst_mode    (dst_mode),
    .reg_write   (reg_write),
    .hold        (hold),
    .bubble      (bubble),
    .src_a       (src_a),
    .src_b       (src_b),
    .stage_dst   (stage_dst),
    .stage_we    (stage_we),
    .wb_dst      (wb_dst),
    .wb_we       (wb_we),
    .fwd_a_hit   (fwd_a_hit),
    .fwd_b_hit   (fwd_b_hit),
    .fwd_a_stage (fwd_a_stage),
    .fwd_b_stage (fwd_b_stage)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic ent_t model_ent(int k);
    ent_t e;
    e = '0;
    if (k < exp_q.size()) e = exp_q[k];
    return e;
  endfunction

  // Expected entry for the instruction being presented
  function automatic ent_t sel_ent(logic [AW-1:0] t, logic [AW-1:0] d,
                                   logic [1:0] m, logic w);
    ent_t e;
    if (m == 2'b01)      e.dst = d;
    else if (m == 2'b10) e.dst = 5'd31;
    else                 e.dst = t;
    e.we = w && (m != 2'b11) && (e.dst != 5'd0);
    return e;
  endfunction

  // Expected forwarding result for one source from the scoreboard
  task automatic exp_fwd(input logic [AW-1:0] s, output logic h, output logic [SW-1:0] st);
    ent_t e;
    h  = 1'b0;
    st = '0;
`ifdef DEST_FWD_CMP_EN
    for (int k = 0; k < DEPTH; k++) begin
      e = model_ent(k);
      if (!h && e.we && e.dst == s && s != 0) begin
        h  = 1'b1;
        st = SW'(k);
      end
    end
`endif
  endtask

  // Compare every stage, wb aliases and forwarding against the scoreboard
  task automatic check_all();
    ent_t e;
    logic h;
    logic [SW-1:0] st;
    for (int k = 0; k < DEPTH; k++) begin
      e = model_ent(k);
      chk($sformatf("stage%0d_dst", k), 32'(stage_dst[k*AW +: AW]), 32'(e.dst));
      chk($sformatf("stage%0d_we", k), 32'(stage_we[k]), 32'(e.we));
    end
    e = model_ent(DEPTH - 1);
    chk("wb_dst", 32'(wb_dst), 32'(e.dst));
    chk("wb_we", 32'(wb_we), 32'(e.we));
    exp_fwd(src_a, h, st);
    chk("fwd_a_hit", 32'(fwd_a_hit), 32'(h));
    chk("fwd_a_stage", 32'(fwd_a_stage), 32'(st));
    exp_fwd(src_b, h, st);
    chk("fwd_b_hit", 32'(fwd_b_hit), 32'(h));
    chk("fwd_b_stage", 32'(fwd_b_stage), 32'(st));
  endtask

  // Drive one cycle of stimulus, update the scoreboard, check after the edge
  task automatic step(input logic [AW-1:0] t, input logic [AW-1:0] d,
                      input logic [1:0] m, input logic w,
                      input logic h, input logic b, input logic r);
    ent_t e;
    rt = t; rd = d; dst_mode = m; reg_write = w;
    hold = h; bubble = b; reset = r;
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
    end else if (!h) begin
      e = b ? ent_t'('0) : sel_ent(t, d, m, w);
      exp_q.push_front(e);
      if (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    end
    check_all();
  endtask

  task automatic nop();
    step(5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [AW-1:0] snap_dst;
    logic [DEPTH-1:0] snap_we;
    rt = 0; rd = 0; dst_mode = 0; reg_write = 0;
    hold = 0; bubble = 0; reset = 1; src_a = 0; src_b = 0;
    @(posedge clk); #1;

    // Reset state
    step(5'd3, 5'd4, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_stage_we", 32'(stage_we), 32'd0);
    chk("rst_wb_we", 32'(wb_we), 32'd0);

    // rd selection flows through all stages
    step(5'd8, 5'd9, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rd_stage0", 32'(stage_dst[AW-1:0]), 32'd9);
    nop(); nop();
    chk("rd_wb_dst", 32'(wb_dst), 32'd9);
    chk("rd_wb_we", 32'(wb_we), 32'd1);

    // Link mode and reserved mode
    step(5'd8, 5'd9, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    nop(); nop();
    chk("link_wb_dst", 32'(wb_dst), 32'd31);
    chk("link_wb_we", 32'(wb_we), 32'd1);
    step(5'd12, 5'd13, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    nop(); nop();
    chk("rsvd_wb_we", 32'(wb_we), 32'd0);

    // Write to $0 dropped; src 0 never hits
    src_a = 5'd0;
    step(5'd6, 5'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("zero_stage0_we", 32'(stage_we[0]), 32'd0);
    chk("zero_fwd_a", 32'(fwd_a_hit), 32'd0);

    // Fill, hold two cycles, bubble, hold+bubble
    step(5'd1, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'd2, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'd3, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    snap_dst = stage_dst[AW-1:0];
    snap_we  = stage_we;
    step(5'd20, 5'd21, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    step(5'd22, 5'd23, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("hold_stage0", 32'(stage_dst[AW-1:0]), 32'(snap_dst));
    chk("hold_we", 32'(stage_we), 32'(snap_we));
    chk("hold_wb_dst", 32'(wb_dst), 32'd1);
    step(5'd24, 5'd0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("bubble_we0", 32'(stage_we[0]), 32'd0);
    chk("bubble_stage1", 32'(stage_dst[AW +: AW]), 32'd3);
    step(5'd25, 5'd0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("hb_stage1", 32'(stage_dst[AW +: AW]), 32'd3);
    chk("hb_wb_dst", 32'(wb_dst), 32'd2);

    // Forwarding: 5 in stages 0 and 2, then stage 0 non-writing
    src_a = 5'd5; src_b = 5'd7;
    step(5'd5, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'd7, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'd5, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef DEST_FWD_CMP_EN
    chk("fwd_young_hit", 32'(fwd_a_hit), 32'd1);
    chk("fwd_young_stage", 32'(fwd_a_stage), 32'd0);
    chk("fwd_b_stage1", 32'(fwd_b_stage), 32'd1);
`else
    chk("fwd_off_hit", 32'(fwd_a_hit), 32'd0);
`endif
    step(5'd5, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(5'd5, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'd7, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'd5, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef DEST_FWD_CMP_EN
    chk("fwd_old_hit", 32'(fwd_a_hit), 32'd1);
    chk("fwd_old_stage", 32'(fwd_a_stage), 32'd2);
`else
    chk("fwd_off_hit2", 32'(fwd_a_hit), 32'd0);
`endif

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      src_a = (i % 2 == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      src_b = AW'($urandom_range(0, 7));
      step(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
           2'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 6) == 0),
           1'($urandom_range(0, 40) == 0));
    end

    // Reset with three writes in flight
    step(5'd10, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'd11, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'd12, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_we", 32'(stage_we), 32'd7);
    step(5'd13, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_we", 32'(stage_we), 32'd0);
    chk("mid_rst_wb_we", 32'(wb_we), 32'd0);
    nop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
